// File: rtl/filter_window_sequencer.sv
// -----------------------------------------------------------------------------
// filter_window_sequencer
//
// Drives a 3x3 neighbourhood filter over a whole frame. The source frame
// buffer is walked in raster order. For each pixel the nine RGB444 taps are
// fetched with edge replication at the borders and packed into a 108-bit
// window. The block then waits out the filter latency and writes the filtered
// pixel to the destination frame buffer at y*IMG_W+x.
//
// Parameters
//   IMG_W, IMG_H  frame size in pixels/lines (each >= 2)
//   ADDR_W        frame-buffer address width (2^ADDR_W >= IMG_W*IMG_H)
//   FILTER_LAT    cycles from window_valid to a valid filter_rgb_in (>= 1)
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous, active-low reset
//   start          one-cycle frame start pulse, honoured only when idle
//   busy           high from the cycle after an accepted start to the last write
//   done           one-cycle pulse in the cycle after the last write
//   rd_addr        source read address (1-cycle synchronous read)
//   rd_data        source pixel for the previous cycle's rd_addr
//   color_data     packed window: centre,L,R,U,D,UL,UR,DL,DR from MSB down
//   window_valid   one-cycle pulse, color_data holds a new window
//   filter_rgb_in  filter output
//   wr_en          destination write strobe
//   wr_addr        destination address
//   wr_data        destination pixel (filter_rgb_in passed through)
// -----------------------------------------------------------------------------
module filter_window_sequencer #(
  parameter int IMG_W      = 160,
  parameter int IMG_H      = 120,
  parameter int ADDR_W     = 15,
  parameter int FILTER_LAT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [11:0]       rd_data,
  output logic [107:0]      color_data,
  output logic              window_valid,
  input  logic [11:0]       filter_rgb_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data
);

  localparam int X_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int Y_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int L_W = (FILTER_LAT > 1) ? $clog2(FILTER_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_WAIT,
    S_WRITE
  } state_t;

  state_t              r_state;
  logic [X_W-1:0]      r_x;
  logic [Y_W-1:0]      r_y;
  logic [3:0]          r_k;
  logic [L_W-1:0]      r_wait;
  logic [ADDR_W-1:0]   r_pix_addr;   // y*IMG_W+x of the current pixel
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [107:0]        r_color;
  logic                r_valid;
  logic                r_done;
  logic [11:0]         r_win [0:7];  // taps 0..7; tap 8 goes straight to color_data
  logic                w_last_pix;

  // Address of tap k around (x,y), with coordinates clamped to the frame so
  // border pixels replicate their edge neighbours.
  function automatic logic [ADDR_W-1:0] tap_addr(input logic [X_W-1:0] x,
                                                 input logic [Y_W-1:0] y,
                                                 input logic [3:0]     k);
    int dx;
    int dy;
    int xc;
    int yc;
    dx = 0;
    dy = 0;
    case (k)
      4'd1:    begin dx = -1; dy =  0; end
      4'd2:    begin dx =  1; dy =  0; end
      4'd3:    begin dx =  0; dy = -1; end
      4'd4:    begin dx =  0; dy =  1; end
      4'd5:    begin dx = -1; dy = -1; end
      4'd6:    begin dx =  1; dy = -1; end
      4'd7:    begin dx = -1; dy =  1; end
      4'd8:    begin dx =  1; dy =  1; end
      default: begin dx =  0; dy =  0; end
    endcase
    xc = int'(x) + dx;
    yc = int'(y) + dy;
    if (xc < 0)      xc = 0;
    if (xc > IMG_W-1) xc = IMG_W - 1;
    if (yc < 0)      yc = 0;
    if (yc > IMG_H-1) yc = IMG_H - 1;
    return ADDR_W'(yc * IMG_W + xc);
  endfunction

  assign w_last_pix = (r_x == X_W'(IMG_W - 1)) && (r_y == Y_W'(IMG_H - 1));

  always_ff @(posedge clk) begin
    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values; reset is synchronous, so it is
    // just the highest-priority branch of the clocked block.
    if (!reset) begin
      r_state    <= S_IDLE;
      r_x        <= '0;
      r_y        <= '0;
      r_k        <= '0;
      r_wait     <= '0;
      r_pix_addr <= '0;
      r_rd_addr  <= '0;
      r_color    <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A start landing on the done cycle belongs to the finished frame.
          if (start && !r_done) begin
            r_state    <= S_FETCH;
            r_x        <= '0;
            r_y        <= '0;
            r_k        <= '0;
            r_pix_addr <= '0;
            r_rd_addr  <= '0;
          end
        end
        S_FETCH: begin
          if (r_k == 4'd8) begin
            r_state <= S_CAPTURE;
          end else begin
            r_k       <= r_k + 4'd1;
            r_rd_addr <= tap_addr(r_x, r_y, r_k + 4'd1);
          end
        end
        S_CAPTURE: begin
          r_color <= {r_win[0], r_win[1], r_win[2], r_win[3],
                      r_win[4], r_win[5], r_win[6], r_win[7], rd_data};
          r_valid <= 1'b1;
          r_wait  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_wait == L_W'(FILTER_LAT - 1)) begin
            r_state <= S_WRITE;
          end else begin
            r_wait <= r_wait + L_W'(1);
          end
        end
        S_WRITE: begin
          r_k <= '0;
          if (w_last_pix) begin
            r_state    <= S_IDLE;
            r_done     <= 1'b1;
            r_x        <= '0;
            r_y        <= '0;
            r_pix_addr <= '0;
            r_rd_addr  <= '0;
          end else begin
            r_state    <= S_FETCH;
            r_pix_addr <= r_pix_addr + ADDR_W'(1);
            // Centre tap of the next raster pixel is simply the next address.
            r_rd_addr  <= r_pix_addr + ADDR_W'(1);
            if (r_x == X_W'(IMG_W - 1)) begin
              r_x <= '0;
              r_y <= r_y + Y_W'(1);
            end else begin
              r_x <= r_x + X_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the window slots are plain storage with no reset; every slot is
  // rewritten before it is read, and color_data itself is reset.
  always_ff @(posedge clk) begin
    if (r_state == S_FETCH && r_k != 4'd0) begin
      r_win[3'(r_k - 4'd1)] <= rd_data;
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;
  assign rd_addr      = r_rd_addr;
  assign color_data   = r_color;
  assign window_valid = r_valid;
  assign wr_en        = (r_state == S_WRITE);
  assign wr_addr      = r_pix_addr;
  assign wr_data      = wr_en ? filter_rgb_in : 12'd0;

endmodule

// File: tb/tb_filter_window_sequencer.sv
// -----------------------------------------------------------------------------
// tb_filter_window_sequencer
//
// Two 4x3 instances: A with FILTER_LAT=3, B with FILTER_LAT=1. Each source
// frame buffer returns its address as pixel data one cycle after rd_addr, and
// each filter is a register chain copying the centre tap, so every write is
// expected to carry its own address. Expected writes are queued when a frame
// is started and popped by a monitor as wr_en appears.
// -----------------------------------------------------------------------------
module tb_filter_window_sequencer;

  localparam int AW = 15;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [11:0]   data;
  } wr_t;

  logic          clk;
  logic          reset;
  int            cyc = 0;
  int            errors = 0;
  int            checks = 0;

  // Instance A signals
  logic          start_a;
  logic          busy_a, done_a, win_valid_a, wr_en_a;
  logic [AW-1:0] rd_addr_a, wr_addr_a;
  logic [11:0]   rd_data_a, filt_a, wr_data_a;
  logic [107:0]  color_a;
  logic [11:0]   fa [0:2];

  // Instance B signals
  logic          start_b;
  logic          busy_b, done_b, win_valid_b, wr_en_b;
  logic [AW-1:0] rd_addr_b, wr_addr_b;
  logic [11:0]   rd_data_b, filt_b, wr_data_b;
  logic [107:0]  color_b;

  wr_t           q_a[$];
  wr_t           q_b[$];
  logic [107:0]  win_log[$];

  int wr_count_a = 0, nvalid_a = 0, first_cyc_a = 0, first_valid_a = 0;
  int valid_cyc_a = 0, last_wr_a = 0;
  int wr_count_b = 0, valid_cyc_b = 0, last_wr_b = 0;
  logic prev_busy_a = 1'b0, prev_wr_a = 1'b0, prev_wr_b = 1'b0;

  filter_window_sequencer #(.IMG_W(4), .IMG_H(3), .ADDR_W(AW), .FILTER_LAT(3)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .color_data(color_a),
    .window_valid(win_valid_a), .filter_rgb_in(filt_a), .wr_en(wr_en_a),
    .wr_addr(wr_addr_a), .wr_data(wr_data_a)
  );

  filter_window_sequencer #(.IMG_W(4), .IMG_H(3), .ADDR_W(AW), .FILTER_LAT(1)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .color_data(color_b),
    .window_valid(win_valid_b), .filter_rgb_in(filt_b), .wr_en(wr_en_b),
    .wr_addr(wr_addr_b), .wr_data(wr_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Source frame buffers: pixel value equals its address, 1-cycle read.
  always @(posedge clk) begin
    rd_data_a <= 12'(rd_addr_a);
    rd_data_b <= 12'(rd_addr_b);
  end

  // Filter models: centre tap delayed by FILTER_LAT registers.
  always @(posedge clk) begin
    fa[0]  <= color_a[107:96];
    fa[1]  <= fa[0];
    fa[2]  <= fa[1];
    filt_b <= color_b[107:96];
  end
  assign filt_a = fa[2];

  task automatic check(input string tag, input logic [107:0] got, input logic [107:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [107:0] win9(input int c, input int l, input int r,
                                        input int u, input int d, input int ul,
                                        input int ur, input int dl, input int dr);
    return {12'(c), 12'(l), 12'(r), 12'(u), 12'(d), 12'(ul), 12'(ur), 12'(dl), 12'(dr)};
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"},   108'(busy_a),       108'd0);
    check({tag, "_done"},   108'(done_a),       108'd0);
    check({tag, "_wr_en"},  108'(wr_en_a),      108'd0);
    check({tag, "_wvalid"}, 108'(win_valid_a),  108'd0);
    check({tag, "_rdaddr"}, 108'(rd_addr_a),    108'd0);
    check({tag, "_wraddr"}, 108'(wr_addr_a),    108'd0);
    check({tag, "_wrdata"}, 108'(wr_data_a),    108'd0);
    check({tag, "_color"},  color_a,            108'd0);
  endtask

  task automatic push_frame_a();
    for (int i = 0; i < 12; i++) q_a.push_back('{addr: AW'(i), data: 12'(i)});
  endtask

  task automatic clear_stats_a();
    wr_count_a = 0;
    nvalid_a   = 0;
    win_log.delete();
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string tag, input int budget);
    int n = 0;
    while (!done_a && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 108'(done_a), 108'd1);
  endtask

  // Monitor for instance A: scoreboard pop, latency, hold and done timing.
  always @(negedge clk) begin
    if (busy_a && !prev_busy_a) first_cyc_a = cyc;
    if (win_valid_a) begin
      if (nvalid_a == 0) first_valid_a = cyc;
      nvalid_a++;
      valid_cyc_a = cyc;
      win_log.push_back(color_a);
    end
    if (wr_en_a) begin
      wr_t e;
      check("a_no_consecutive_wr", 108'(prev_wr_a), 108'd0);
      check("a_wr_expected", 108'(q_a.size() != 0), 108'd1);
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        check("a_wr_addr", 108'(wr_addr_a), 108'(e.addr));
        check("a_wr_data", 108'(wr_data_a), 108'(e.data));
      end
      check("a_wr_latency", 108'(cyc - valid_cyc_a), 108'd3);
      if (win_log.size() != 0) check("a_color_hold", color_a, win_log[$]);
      wr_count_a++;
      last_wr_a = cyc;
    end
    if (done_a) begin
      check("a_done_after_last_wr", 108'(cyc - last_wr_a), 108'd1);
      check("a_busy_low_at_done", 108'(busy_a), 108'd0);
    end
    prev_busy_a = busy_a;
    prev_wr_a   = wr_en_a;
  end

  // Monitor for instance B: FILTER_LAT=1 timing and pass-through.
  always @(negedge clk) begin
    if (win_valid_b) valid_cyc_b = cyc;
    if (wr_en_b) begin
      wr_t e;
      check("b_no_consecutive_wr", 108'(prev_wr_b), 108'd0);
      check("b_wr_expected", 108'(q_b.size() != 0), 108'd1);
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        check("b_wr_addr", 108'(wr_addr_b), 108'(e.addr));
        check("b_wr_data", 108'(wr_data_b), 108'(e.data));
      end
      check("b_wr_latency", 108'(cyc - valid_cyc_b), 108'd1);
      check("b_wr_passthrough", 108'(wr_data_b), 108'(filt_b));
      if (wr_count_b > 0) check("b_pixel_period", 108'(cyc - last_wr_b), 108'd12);
      wr_count_b++;
      last_wr_b = cyc;
    end
    prev_wr_b = wr_en_b;
  end

  initial begin
    int n;
    reset   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b1;
    @(negedge clk);

    // Frame 1: full sweep, with a stray start in the middle of the frame.
    clear_stats_a();
    push_frame_a();
    pulse_start_a();
    check("a_busy_after_start", 108'(busy_a), 108'd1);
    check("a_first_rd_addr", 108'(rd_addr_a), 108'd0);
    repeat (40) @(negedge clk);
    pulse_start_a();
    wait_done_a("a_frame1_done", 400);
    check("a_frame1_writes", 108'(wr_count_a), 108'd12);
    check("a_frame1_queue_empty", 108'(q_a.size()), 108'd0);
    check("a_frame_time", 108'(last_wr_a - first_cyc_a + 1), 108'd168);
    check("a_first_window_cycle", 108'(first_valid_a - first_cyc_a), 108'd10);
    check("a_window_count", 108'(win_log.size()), 108'd12);
    if (win_log.size() == 12) begin
      check("a_win_px00", win_log[0],  win9(0, 0, 1, 0, 4, 0, 1, 4, 5));
      check("a_win_px11", win_log[5],  win9(5, 4, 6, 1, 9, 0, 2, 8, 10));
      check("a_win_px32", win_log[11], win9(11, 10, 11, 7, 11, 6, 7, 10, 11));
    end
    // Start on the done cycle must be ignored.
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("a_start_on_done_ignored", 108'(busy_a), 108'd0);
    repeat (3) @(negedge clk);
    check("a_still_idle", 108'(busy_a), 108'd0);

    // Frame 2, then a start one cycle after its done (frame 3).
    clear_stats_a();
    push_frame_a();
    pulse_start_a();
    wait_done_a("a_frame2_done", 400);
    check("a_frame2_writes", 108'(wr_count_a), 108'd12);
    @(negedge clk);
    clear_stats_a();
    push_frame_a();
    pulse_start_a();
    check("a_start_after_done_taken", 108'(busy_a), 108'd1);

    // Frame 3: reset during the first WAIT cycle of pixel 5.
    n = 0;
    while (!(win_valid_a && wr_count_a == 5) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("a_px5_window_seen", 108'(win_valid_a && wr_count_a == 5), 108'd1);
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("mid");
    reset = 1'b1;
    repeat (30) @(negedge clk);
    check("a_reset_writes", 108'(wr_count_a), 108'd5);
    check("a_reset_px5_unwritten", 108'(q_a.size()), 108'd7);
    q_a.delete();

    // Frame 4: restart after reset rewrites from address 0.
    clear_stats_a();
    push_frame_a();
    pulse_start_a();
    wait_done_a("a_frame4_done", 400);
    check("a_frame4_writes", 108'(wr_count_a), 108'd12);
    check("a_frame4_queue_empty", 108'(q_a.size()), 108'd0);

    // Instance B: FILTER_LAT=1.
    for (int i = 0; i < 12; i++) q_b.push_back('{addr: AW'(i), data: 12'(i)});
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    n = 0;
    while (!done_b && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("b_done", 108'(done_b), 108'd1);
    check("b_writes", 108'(wr_count_b), 108'd12);
    check("b_queue_empty", 108'(q_b.size()), 108'd0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/filter_window_sequencer.md
# filter_window_sequencer

Sequences the 3x3 neighbourhood pixel filter over a full frame. It walks the source frame buffer in raster order and fetches the nine RGB444 neighbours of each pixel. It packs them into the 108-bit window bus consumed by the filter, waits out the filter's pipeline latency, and writes each filtered pixel into the destination frame buffer. It sits between the frame buffers and the filter module and is started once per frame by the top-level control.

## Interface
- IMG_W, 160: frame width in pixels (>=2).
- IMG_H, 120: frame height in lines (>=2).
- ADDR_W, 15: frame-buffer address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- FILTER_LAT, 3: filter latency; cycles from window_valid to a valid filter_rgb_in (>=1).
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse to begin a frame; ignored unless idle.
- busy  out  1  high from the cycle after an accepted start through the last write.
- done  out  1  one-cycle pulse in the cycle after the frame's last write.
- rd_addr  out  ADDR_W  source frame-buffer read address; 1-cycle synchronous read latency.
- rd_data  in  12  source pixel {R[3:0],G[3:0],B[3:0]} for the rd_addr of the previous cycle.
- color_data  out  108  packed window driven to the filter.
- window_valid  out  1  one-cycle pulse; color_data holds a complete new window.
- filter_rgb_in  in  12  filter output.
- wr_en  out  1  destination write strobe.
- wr_addr  out  ADDR_W  destination address, y*IMG_W+x.
- wr_data  out  12  destination pixel.

## Operation
- color_data packing (12 bits per tap): [107:96] centre, [95:84] left, [83:72] right, [71:60] up, [59:48] down, [47:36] up-left, [35:24] up-right, [23:12] down-left, [11:0] down-right.
- Fetch order, tap index k=0..8: centre, left, right, up, down, up-left, up-right, down-left, down-right.
- Borders: neighbour coordinates are clamped (replicate edge) before forming the address.
  - x-1 at x=0 becomes 0; x+1 at x=IMG_W-1 becomes IMG_W-1.
  - y is clamped the same way.
  - Tap address = yc*IMG_W + xc.
- FSM states:
  - IDLE: start -> FETCH with x=y=0, k=0.
  - FETCH: 9 cycles; drives rd_addr for tap k and captures rd_data into slot k-1 when k>0. After k=8 -> CAPTURE.
  - CAPTURE: 1 cycle; captures tap 8 into its slot, then transfers the full window to color_data -> WAIT.
  - WAIT: FILTER_LAT cycles; window_valid is high in the first WAIT cycle only -> WRITE.
  - WRITE: 1 cycle. wr_en=1, wr_addr=y*IMG_W+x, wr_data=filter_rgb_in (combinational pass-through). Then:
    - x=IMG_W-1 and y=IMG_H-1 -> IDLE, with done the following cycle.
    - otherwise advance x (wrap to 0 and increment y at IMG_W-1) -> FETCH.
- color_data holds between windows; it changes only on the CAPTURE->WAIT transition.
- start while busy: ignored, no effect on the current frame.
- Reset in any state: synchronous return to IDLE, all counters zeroed, no further writes; any partial frame is abandoned.
- Reset values: busy=0, done=0, wr_en=0, window_valid=0, rd_addr=0, wr_addr=0, wr_data=0, color_data=0.

## Timing
- start sampled high in IDLE in cycle T: FETCH k=0 in T+1 (busy=1 from T+1), rd_addr=centre address.
- Pixel period: 9 + 1 + FILTER_LAT + 1 = 11+FILTER_LAT cycles; default 14.
- window_valid occurs at cycle 10 of the pixel (0-based from its first FETCH); WRITE occurs at cycle 10+FILTER_LAT.
- Frame time: IMG_W*IMG_H*(11+FILTER_LAT) cycles from T+1 to the last WRITE inclusive.
- done is high in the cycle after the last WRITE; busy falls in that same cycle.
- A start coincident with done: ignored. A start one cycle later: accepted.
- Exactly one wr_en per pixel; never two consecutive wr_en cycles.

## Test plan
- Frame sweep, IMG_W=4, IMG_H=3, FILTER_LAT=3, source pixel value = address, filter model = registered 3-stage copy of the centre tap:
  - 12 writes, addresses 0..11 in order, wr_data = address.
  - done 1 cycle after the write to address 11; 168 cycles from first FETCH to last write.
- Corner clamp, pixel (0,0), 4x3 frame, source = address:
  - color_data = {0,0,1,0,4,0,1,4,5} in packing order.
- Corner clamp, pixel (3,2):
  - color_data = {11,10,11,7,11,6,7,10,11}.
  - Same frame, interior pixel (1,1): {5,4,6,1,9,0,2,8,10}.
- Handshake:
  - start re-pulsed mid-frame: no restart, write count stays 12.
  - start pulsed the cycle after done: second frame runs normally.
- Reset mid-frame: reset low during pixel 5's WAIT state:
  - no wr_en for pixel 5; all outputs at reset values the next cycle.
  - A new start then rewrites from address 0.
- Latency parameter, FILTER_LAT=1:
  - pixel period 12; wr_en exactly 1 cycle after window_valid.
  - wr_data equals filter_rgb_in in that cycle.
